phase_wrapper: RTL and testbench

Running phase accumulator for the Red Pitaya Boltzmann signal chain. It takes a signed 14-bit phase sample every clock and integrates it into a signed 15-bit sum. The sum wraps modulo 2^15 by default, so a full 2^15 range maps to one phase turn. It sits between the ADC-side phase source and downstream phase consumers, and is fully pipelined with no handshake.

---
 rtl/phase_pkg.sv | 14 +
 rtl/phase_sat_add.sv | 41 ++++
 rtl/phase_wrapper.sv | 66 ++++++
 tb/tb_phase_wrapper.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/phase_pkg.sv
// Shared types and defaults for the phase signal chain.
//   PHASE_DATA_W : default width of a signed phase increment sample
//   PHASE_SUM_W  : default width of the signed accumulated phase
//   sample_t     : signed phase increment at the default width
//   sum_t        : signed accumulated phase at the default width
package phase_pkg;

  localparam int unsigned PHASE_DATA_W = 14;
  localparam int unsigned PHASE_SUM_W  = 15;

  typedef logic signed [PHASE_DATA_W-1:0] sample_t;
  typedef logic signed [PHASE_SUM_W-1:0]  sum_t;

endpackage

// File: rtl/phase_sat_add.sv
// Combinational signed add of an accumulator and a narrower sign-extended
// increment. The sum is formed one bit wider than the accumulator, then
// either truncated (natural wrap) or clamped to the signed SUM_W range.
//   acc_i : signed accumulator operand, SUM_W bits
//   inc_i : signed increment operand, DATA_W bits
//   sum_o : wrapped or saturated result, SUM_W bits
//   ovf_o : high when the exact sum does not fit in SUM_W bits
module phase_sat_add
  import phase_pkg::*;
#(
  parameter int unsigned DATA_W   = PHASE_DATA_W,
  parameter int unsigned SUM_W    = PHASE_SUM_W,
  parameter int unsigned SATURATE = 0
) (
  input  logic signed [SUM_W-1:0]  acc_i,
  input  logic signed [DATA_W-1:0] inc_i,
  output logic signed [SUM_W-1:0]  sum_o,
  output logic                     ovf_o
);

  localparam int unsigned EXT_W = SUM_W + 1 - DATA_W;
  localparam logic signed [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  logic signed [SUM_W:0] acc_x;
  logic signed [SUM_W:0] inc_x;
  logic signed [SUM_W:0] full;

  always_comb begin
    acc_x = {acc_i[SUM_W-1], acc_i};
    inc_x = {{EXT_W{inc_i[DATA_W-1]}}, inc_i};
    full  = acc_x + inc_x;
    // The exact sum fits in SUM_W bits iff its top two bits agree.
    ovf_o = full[SUM_W] ^ full[SUM_W-1];
    sum_o = full[SUM_W-1:0];
    if ((SATURATE != 0) && ovf_o) begin
      sum_o = full[SUM_W] ? SUM_MIN : SUM_MAX;
    end
  end

endmodule

// File: rtl/phase_wrapper.sv
// Running phase accumulator. Every clock a signed DATA_W sample is
// registered, then added into a signed SUM_W accumulator that either wraps
// (one full 2^SUM_W range is one phase turn) or saturates.
// Input-to-output latency is two clocks, one sample per clock, no handshake.
//   clk_i  : clock, rising edge
//   reset  : synchronous, active-low; clears input register and accumulator
//   data_i : signed phase increment, DATA_W bits
//   sum_o  : signed accumulated phase, SUM_W bits, registered
module phase_wrapper
  import phase_pkg::*;
#(
  parameter int unsigned DATA_W   = PHASE_DATA_W,
  parameter int unsigned SUM_W    = PHASE_SUM_W,
  parameter int unsigned SATURATE = 0
) (
  input  logic                     clk_i,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] data_i,
  output logic signed [SUM_W-1:0]  sum_o
);

  localparam logic signed [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  if (SUM_W <= DATA_W) begin : g_bad_widths
    $error("phase_wrapper: SUM_W must be wider than DATA_W");
  end

  logic signed [DATA_W-1:0] d_q;
  logic signed [SUM_W-1:0]  acc;
  logic signed [SUM_W-1:0]  sum_nxt;
  logic                     ovf;

  phase_sat_add #(
    .DATA_W   (DATA_W),
    .SUM_W    (SUM_W),
    .SATURATE (SATURATE)
  ) u_add (
    .acc_i (acc),
    .inc_i (d_q),
    .sum_o (sum_nxt),
    .ovf_o (ovf)
  );

  // Reset wins over accumulation and flushes any sample held in d_q,
  // so X on data_i during reset never reaches the accumulator.
  always_ff @(posedge clk_i) begin
    if (!reset) begin
      d_q <= '0;
      acc <= '0;
    end else begin
      d_q <= data_i;
      acc <= sum_nxt;
    end
  end

  assign sum_o = acc;

  // In saturating mode an overflowing add must land exactly on a limit.
  always_ff @(posedge clk_i) begin
    if (reset && ovf && (SATURATE != 0)) begin
      assert (sum_nxt == SUM_MAX || sum_nxt == SUM_MIN);
    end
  end

endmodule

// File: tb/tb_phase_wrapper.sv
module tb_phase_wrapper;

  localparam int DW = 14;
  localparam int SW = 15;
  localparam int HALF = 1 << (SW - 1);
  localparam int FULL = 1 << SW;

  logic                 clk_i;
  logic                 reset;
  logic signed [DW-1:0] data_i;
  logic signed [SW-1:0] sum_wrap;
  logic signed [SW-1:0] sum_sat;

  phase_wrapper #(.DATA_W(DW), .SUM_W(SW), .SATURATE(0)) u_wrap (
    .clk_i  (clk_i),
    .reset  (reset),
    .data_i (data_i),
    .sum_o  (sum_wrap)
  );

  phase_wrapper #(.DATA_W(DW), .SUM_W(SW), .SATURATE(1)) u_sat (
    .clk_i  (clk_i),
    .reset  (reset),
    .data_i (data_i),
    .sum_o  (sum_sat)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int    w;
    int    s;
    string tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference: exact integer phase, reduced to the signed range afterwards.
  int m_wrap = 0;
  int m_sat  = 0;
  int held   = 0;   // sample captured by the previous edge, added next edge

  function automatic int wrap_fn(input int x);
    int m;
    m = x % FULL;
    if (m < 0) m += FULL;
    if (m >= HALF) m -= FULL;
    return m;
  endfunction

  function automatic int clamp_fn(input int x);
    if (x > HALF - 1) return HALF - 1;
    if (x < -HALF) return -HALF;
    return x;
  endfunction

  // Drive one edge's inputs and queue the sum expected right after it.
  task automatic step(input bit r, input int d, input bit xdat, input string tag);
    exp_t e;
    @(negedge clk_i);
    reset = r;
    if (xdat) data_i = 'x;
    else data_i = DW'(d);
    if (!r) begin
      m_wrap = 0;
      m_sat  = 0;
      held   = 0;
    end else begin
      m_wrap = wrap_fn(m_wrap + held);
      m_sat  = clamp_fn(m_sat + held);
      held   = d;
    end
    e.w = m_wrap;
    e.s = m_sat;
    e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor: one output per clock, checked 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (int'(sum_wrap) != e.w) begin
          n_bad++;
          $display("FAIL %s wrap: sum_o=%0d expected %0d", e.tag, sum_wrap, e.w);
        end
        n_cmp++;
        if (int'(sum_sat) != e.s) begin
          n_bad++;
          $display("FAIL %s sat: sum_o=%0d expected %0d", e.tag, sum_sat, e.s);
        end
      end
    end
  end

  initial begin
    bit r;
    int d;
    reset  = 1'b0;
    data_i = '0;

    // Reset hold with undriven data, then ramp 100, 300, 500, ...
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, "reset_hold");
    for (int i = 0; i < 7; i++) step(1'b1, 100 + 200 * i, 1'b0, "ramp");
    // Mid-stream reset for one edge, then carry on ramping
    step(1'b0, 1500, 1'b0, "mid_reset");
    for (int i = 0; i < 4; i++) step(1'b1, 1700 + 200 * i, 1'b0, "post_reset");

    // Preload to 16000, overflow by +1000, then back and run negative
    step(1'b0, 0, 1'b0, "reset_preload");
    for (int i = 0; i < 16; i++) step(1'b1, 1000, 1'b0, "preload");
    step(1'b1, 1000, 1'b0, "overflow");
    step(1'b1, -1000, 1'b0, "back");
    for (int i = 0; i < 7; i++) step(1'b1, -8192, 1'b0, "neg_run");
    for (int i = 0; i < 2; i++) step(1'b1, 0, 1'b0, "flush");

    // Most-negative input from zero
    step(1'b0, 0, 1'b0, "reset_negext");
    for (int i = 0; i < 5; i++) step(1'b1, -8192, 1'b0, "neg_extreme");
    for (int i = 0; i < 2; i++) step(1'b1, 0, 1'b0, "flush");

    // Maximum positive input hitting the upper limit
    step(1'b0, 0, 1'b0, "reset_posext");
    for (int i = 0; i < 6; i++) step(1'b1, 8191, 1'b0, "pos_extreme");

    // Random full-range samples with rare resets
    step(1'b0, 0, 1'b0, "reset_rand");
    for (int i = 0; i < 10000; i++) begin
      r = ($urandom_range(499, 0) != 0);
      d = int'($urandom_range(16383, 0)) - 8192;
      step(r, d, 1'b0, "random");
    end
    // Biased runs that pin the saturating accumulator at each limit
    for (int i = 0; i < 300; i++) step(1'b1, int'($urandom_range(8191, 2000)), 1'b0, "rand_pos");
    for (int i = 0; i < 300; i++) step(1'b1, -int'($urandom_range(8192, 2000)), 1'b0, "rand_neg");
    for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b0, "flush");

    @(posedge clk_i);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
